// File: rtl/nibble_diff_scanner.sv
// nibble_diff_scanner: sequences word pairs onto an external per-nibble
// equality comparator, waits for it to settle, samples its flags and
// accumulates burst statistics reported with a one-cycle done pulse.
module nibble_diff_scanner #(
  parameter int SETTLE_CYC = 10,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      word_a,
  input  logic [15:0]      word_b,
  output logic [15:0]      cmp_a,
  output logic [15:0]      cmp_b,
  input  logic [3:0]       d_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] diff_total,
  output logic [3:0]       eq_words,
  output logic [3:0]       first_idx,
  output logic             any_mismatch
);

  // Counter must hold SETTLE_CYC-1; keep at least one bit when SETTLE_CYC=1.
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {IDLE, WAIT_IN, SETTLE, SAMPLE, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       word_idx_q, word_idx_d;
  logic [3:0]       len_q, len_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [15:0]      cmp_a_q, cmp_a_d, cmp_b_q, cmp_b_d;
  logic [CNT_W-1:0] diff_total_q, diff_total_d;
  logic [3:0]       eq_words_q, eq_words_d;
  logic [3:0]       first_idx_q, first_idx_d;
  logic             any_mismatch_q, any_mismatch_d;
  logic [2:0]       nmis;

  // Mismatch count of the sampled word: one per cleared equality flag.
  always_comb begin
    nmis = 3'(!d_in[0]) + 3'(!d_in[1]) + 3'(!d_in[2]) + 3'(!d_in[3]);
  end

  // Next-state and datapath updates; everything holds unless a state acts.
  always_comb begin
    state_d        = state_q;
    word_idx_d     = word_idx_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    cmp_a_d        = cmp_a_q;
    cmp_b_d        = cmp_b_q;
    diff_total_d   = diff_total_q;
    eq_words_d     = eq_words_q;
    first_idx_d    = first_idx_q;
    any_mismatch_d = any_mismatch_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          diff_total_d   = '0;
          eq_words_d     = '0;
          any_mismatch_d = 1'b0;
          first_idx_d    = 4'hF;
          if (len != 4'd0) begin
            len_d      = len;
            word_idx_d = '0;
            state_d    = WAIT_IN;
          end else begin
            state_d = DONE;
          end
        end
      end
      WAIT_IN: begin
        if (in_valid) begin
          cmp_a_d = word_a;
          cmp_b_d = word_b;
          cnt_d   = CW'(SETTLE_CYC - 1);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = SAMPLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      SAMPLE: begin
        diff_total_d = diff_total_q + CNT_W'(nmis);
        if (d_in == 4'hF) eq_words_d = eq_words_q + 4'd1;
        if (nmis != 3'd0 && !any_mismatch_q) begin
          first_idx_d    = word_idx_q;
          any_mismatch_d = 1'b1;
        end
        if (word_idx_q == 4'(len_q - 4'd1)) begin
          state_d = DONE;
        end else begin
          word_idx_d = word_idx_q + 4'd1;
          state_d    = WAIT_IN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any burst immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      word_idx_q     <= '0;
      len_q          <= '0;
      cnt_q          <= '0;
      cmp_a_q        <= '0;
      cmp_b_q        <= '0;
      diff_total_q   <= '0;
      eq_words_q     <= '0;
      first_idx_q    <= 4'hF;
      any_mismatch_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      word_idx_q     <= word_idx_d;
      len_q          <= len_d;
      cnt_q          <= cnt_d;
      cmp_a_q        <= cmp_a_d;
      cmp_b_q        <= cmp_b_d;
      diff_total_q   <= diff_total_d;
      eq_words_q     <= eq_words_d;
      first_idx_q    <= first_idx_d;
      any_mismatch_q <= any_mismatch_d;
    end
  end

  assign in_ready     = (state_q == WAIT_IN);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign cmp_a        = cmp_a_q;
  assign cmp_b        = cmp_b_q;
  assign diff_total   = diff_total_q;
  assign eq_words     = eq_words_q;
  assign first_idx    = first_idx_q;
  assign any_mismatch = any_mismatch_q;

endmodule

// File: doc/nibble_diff_scanner.md
Name: nibble_diff_scanner

Overview:
- Sequencer wrapped around the 16-bit per-nibble equality comparator (4 equality flags, d[3] = bits 15:12 … d[0] = bits 3:0).
- Accepts a burst of word pairs over a valid/ready handshake and drives each pair onto the comparator's A/B inputs.
- Waits a programmable settle time to cover the comparator's gate-delay chain, then samples the 4 flags.
- Accumulates burst statistics and reports them with a one-cycle done pulse.

Parameters:
- SETTLE_CYC, 10, clock cycles allowed for the comparator to settle before sampling. Minimum 1. The default covers a 79 ns worst-case path at a 10 ns clock.
- CNT_W, 8, width of diff_total.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a burst; sampled only in IDLE
- len  in  4  number of word pairs in the burst, 0..15; latched on start
- in_valid  in  1  word pair present
- in_ready  out  1  block can accept a pair
- word_a  in  16  operand A
- word_b  in  16  operand B
- cmp_a  out  16  registered A driven to the comparator
- cmp_b  out  16  registered B driven to the comparator
- d_in  in  4  comparator nibble-equal flags (1 = nibble equal)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when burst results are valid
- diff_total  out  CNT_W  total mismatched nibbles in the burst
- eq_words  out  4  number of words with all 4 nibbles equal
- first_idx  out  4  index of the first word with any mismatch; 4'hF if none
- any_mismatch  out  1  at least one mismatched nibble in the burst

Behaviour:
- Reset (async, rst=1) forces state IDLE. All outputs go to 0, except first_idx = 4'hF. Internal word index, settle counter and latched len go to 0.
- FSM states: IDLE, WAIT_IN, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 and len!=0: clear diff_total, eq_words and any_mismatch; set first_idx=4'hF; latch len; word_idx=0; go to WAIT_IN.
  - start=1 and len=0: clear results as above and go directly to DONE.
  - start=0: stay in IDLE.
- WAIT_IN:
  - in_ready=1 (in_ready is high only in this state).
  - On in_valid & in_ready at edge k: cmp_a←word_a, cmp_b←word_b, settle counter←SETTLE_CYC-1, go to SETTLE.
- SETTLE: the counter decrements each cycle. Go to SAMPLE on the edge where the counter is 0. cmp_a/cmp_b hold steady.
- SAMPLE (one cycle; d_in is captured at edge k+SETTLE_CYC+1):
  - nmis = 4 - popcount(d_in); diff_total += nmis.
  - If d_in==4'hF, eq_words += 1.
  - If nmis!=0 and any_mismatch==0: first_idx←word_idx and any_mismatch←1.
  - If word_idx==len-1, go to DONE; otherwise word_idx += 1 and go to WAIT_IN.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored while in DONE.
- Per-word throughput with in_valid held high: SETTLE_CYC+2 cycles.
- Result outputs hold their values from DONE until the next start is accepted in IDLE.
- cmp_a/cmp_b hold their last value after the burst ends.
- start outside IDLE is ignored. len changes after latching are ignored.
- diff_total never wraps: the maximum is 60, which is below 2^CNT_W for CNT_W≥6.
- rst asserted mid-burst (any state) aborts immediately to the reset values. No done pulse is produced.
- d_in is used only in SAMPLE. d_in changes outside SAMPLE have no effect.

Test Plan:
- Reset, then start, len=1, A=B=16'h1234 → in_ready in WAIT_IN; d_in=4'hF sampled SETTLE_CYC+1 cycles after accept → done pulse, diff_total=0, eq_words=1, first_idx=4'hF, any_mismatch=0.
- len=3 with pairs (FFFF,FFFF), (1234,1334), (ABCD,0000); model returns 4'hF, 4'b1011, 4'h0 → diff_total=5, eq_words=1, first_idx=1, any_mismatch=1; done exactly 3*(SETTLE_CYC+2)+1 cycles after start with in_valid held high.
- Check d_in changes during SETTLE are ignored: toggle d_in to 4'h0 throughout SETTLE and set d_in=4'hF only in the SAMPLE cycle → word counted as equal.
- start with len=0 → done on the next cycle, diff_total=0, first_idx=4'hF; busy high for one cycle.
- Assert rst during SETTLE of word 2 of a len=4 burst → all outputs return to reset values asynchronously, no done pulse; a new start with len=1 completes normally.
- Pulse start while busy, and while in_valid stalls low for 7 cycles in WAIT_IN → start ignored, cmp_a/cmp_b unchanged, burst resumes and totals are correct.
